// File: rtl/k_const_sequencer.sv
// k_const_sequencer: SHA-2 round-constant streamer with a registered random-access read port
module k_const_sequencer #(
    parameter int MODE = 0,
    localparam int WORD_W = (MODE == 0) ? 32 : 64,
    localparam int ROUNDS = (MODE == 0) ? 64 : 80,
    localparam int AW = 7
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              start,
    input  logic              stall,
    input  logic              abort,
    output logic [WORD_W-1:0] k_out,
    output logic              k_valid,
    output logic [AW-1:0]     round_idx,
    output logic              k_last,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    // The SHA-256 constants are the upper 32 bits of the first 64 SHA-512 constants,
    // so a single 64-bit table serves both modes.
    function automatic logic [63:0] k64(input logic [AW-1:0] a);
        case (a)
            7'd0:  k64 = 64'h428a2f98d728ae22;
            7'd1:  k64 = 64'h7137449123ef65cd;
            7'd2:  k64 = 64'hb5c0fbcfec4d3b2f;
            7'd3:  k64 = 64'he9b5dba58189dbbc;
            7'd4:  k64 = 64'h3956c25bf348b538;
            7'd5:  k64 = 64'h59f111f1b605d019;
            7'd6:  k64 = 64'h923f82a4af194f9b;
            7'd7:  k64 = 64'hab1c5ed5da6d8118;
            7'd8:  k64 = 64'hd807aa98a3030242;
            7'd9:  k64 = 64'h12835b0145706fbe;
            7'd10: k64 = 64'h243185be4ee4b28c;
            7'd11: k64 = 64'h550c7dc3d5ffb4e2;
            7'd12: k64 = 64'h72be5d74f27b896f;
            7'd13: k64 = 64'h80deb1fe3b1696b1;
            7'd14: k64 = 64'h9bdc06a725c71235;
            7'd15: k64 = 64'hc19bf174cf692694;
            7'd16: k64 = 64'he49b69c19ef14ad2;
            7'd17: k64 = 64'hefbe4786384f25e3;
            7'd18: k64 = 64'h0fc19dc68b8cd5b5;
            7'd19: k64 = 64'h240ca1cc77ac9c65;
            7'd20: k64 = 64'h2de92c6f592b0275;
            7'd21: k64 = 64'h4a7484aa6ea6e483;
            7'd22: k64 = 64'h5cb0a9dcbd41fbd4;
            7'd23: k64 = 64'h76f988da831153b5;
            7'd24: k64 = 64'h983e5152ee66dfab;
            7'd25: k64 = 64'ha831c66d2db43210;
            7'd26: k64 = 64'hb00327c898fb213f;
            7'd27: k64 = 64'hbf597fc7beef0ee4;
            7'd28: k64 = 64'hc6e00bf33da88fc2;
            7'd29: k64 = 64'hd5a79147930aa725;
            7'd30: k64 = 64'h06ca6351e003826f;
            7'd31: k64 = 64'h142929670a0e6e70;
            7'd32: k64 = 64'h27b70a8546d22ffc;
            7'd33: k64 = 64'h2e1b21385c26c926;
            7'd34: k64 = 64'h4d2c6dfc5ac42aed;
            7'd35: k64 = 64'h53380d139d95b3df;
            7'd36: k64 = 64'h650a73548baf63de;
            7'd37: k64 = 64'h766a0abb3c77b2a8;
            7'd38: k64 = 64'h81c2c92e47edaee6;
            7'd39: k64 = 64'h92722c851482353b;
            7'd40: k64 = 64'ha2bfe8a14cf10364;
            7'd41: k64 = 64'ha81a664bbc423001;
            7'd42: k64 = 64'hc24b8b70d0f89791;
            7'd43: k64 = 64'hc76c51a30654be30;
            7'd44: k64 = 64'hd192e819d6ef5218;
            7'd45: k64 = 64'hd69906245565a910;
            7'd46: k64 = 64'hf40e35855771202a;
            7'd47: k64 = 64'h106aa07032bbd1b8;
            7'd48: k64 = 64'h19a4c116b8d2d0c8;
            7'd49: k64 = 64'h1e376c085141ab53;
            7'd50: k64 = 64'h2748774cdf8eeb99;
            7'd51: k64 = 64'h34b0bcb5e19b48a8;
            7'd52: k64 = 64'h391c0cb3c5c95a63;
            7'd53: k64 = 64'h4ed8aa4ae3418acb;
            7'd54: k64 = 64'h5b9cca4f7763e373;
            7'd55: k64 = 64'h682e6ff3d6b2b8a3;
            7'd56: k64 = 64'h748f82ee5defb2fc;
            7'd57: k64 = 64'h78a5636f43172f60;
            7'd58: k64 = 64'h84c87814a1f0ab72;
            7'd59: k64 = 64'h8cc702081a6439ec;
            7'd60: k64 = 64'h90befffa23631e28;
            7'd61: k64 = 64'ha4506cebde82bde9;
            7'd62: k64 = 64'hbef9a3f7b2c67915;
            7'd63: k64 = 64'hc67178f2e372532b;
            7'd64: k64 = 64'hca273eceea26619c;
            7'd65: k64 = 64'hd186b8c721c0c207;
            7'd66: k64 = 64'heada7dd6cde0eb1e;
            7'd67: k64 = 64'hf57d4f7fee6ed178;
            7'd68: k64 = 64'h06f067aa72176fba;
            7'd69: k64 = 64'h0a637dc5a2c898a6;
            7'd70: k64 = 64'h113f9804bef90dae;
            7'd71: k64 = 64'h1b710b35131c471b;
            7'd72: k64 = 64'h28db77f523047d84;
            7'd73: k64 = 64'h32caab7b40c72493;
            7'd74: k64 = 64'h3c9ebe0a15c9bebc;
            7'd75: k64 = 64'h431d67c49c100d4c;
            7'd76: k64 = 64'h4cc5d4becb3e42b6;
            7'd77: k64 = 64'h597f299cfc657e2a;
            7'd78: k64 = 64'h5fcb6fab3ad6faec;
            7'd79: k64 = 64'h6c44198c4a475817;
            default: k64 = 64'h0;
        endcase
    endfunction
    // Mode-width view of the table; addresses past the last round read as zero.
    function automatic logic [WORD_W-1:0] rom(input logic [AW-1:0] a);
        logic [63:0] w;
        w = k64(a);
        rom = (a < AW'(ROUNDS)) ? w[63 -: WORD_W] : '0;
    endfunction
    // Stream FSM: outputs are loaded together with the state so every output is a flop.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            k_out     <= '0;
            k_valid   <= 1'b0;
            round_idx <= '0;
            k_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                k_out     <= '0;
                k_valid   <= 1'b0;
                round_idx <= '0;
                k_last    <= 1'b0;
                busy      <= 1'b0;
            end else if (state == IDLE) begin
                if (start) begin
                    state     <= RUN;
                    k_out     <= rom('0);
                    k_valid   <= 1'b1;
                    round_idx <= '0;
                    k_last    <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (!stall) begin
                if (k_last) begin
                    done      <= 1'b1;
                    state     <= start ? RUN : IDLE;
                    k_out     <= start ? rom('0) : '0;
                    k_valid   <= start;
                    round_idx <= '0;
                    k_last    <= 1'b0;
                    busy      <= start;
                end else begin
                    round_idx <= round_idx + 1'b1;
                    k_out     <= rom(round_idx + 1'b1);
                    k_last    <= round_idx == AW'(ROUNDS - 2);
                end
            end
        end
    end
    // Debug read port, independent of the stream; holds its value when not enabled.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) rd_data <= '0;
        else if (rd_en) rd_data <= rom(rd_addr);
    end
endmodule

// File: doc/k_const_sequencer.md
Name: k_const_sequencer

Overview:
- Parametrised round-constant source for the SHA compression core.
- Streams the round constants K[0..ROUNDS-1] in order, one per accepted cycle, with start, stall, last and done handshakes.
- Has a second, independent random-access read port with one-cycle registered latency, for debug and verification.
- MODE selects SHA-256 (64 × 32-bit constants) or SHA-512 (80 × 64-bit constants). The same block serves both compression-core generations.

Parameters:
- MODE, 0, constant set: 0 = SHA-224/256, 1 = SHA-384/512.
- WORD_W, derived localparam: 32 when MODE=0, 64 when MODE=1.
- ROUNDS, derived localparam: 64 when MODE=0, 80 when MODE=1.
- AW, derived localparam: 7. Fixed so that the port widths are the same in both modes.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_l  in  1  asynchronous, active-low reset.
- start  in  1  begin a new constant stream. Sampled only when the stream port is ready to begin (see Behaviour).
- stall  in  1  consumer back-pressure. While high, the stream outputs and the counter hold.
- abort  in  1  terminate the stream; return to IDLE.
- k_out  out  WORD_W  current round constant.
- k_valid  out  1  k_out is valid for round round_idx.
- round_idx  out  AW  round number of k_out.
- k_last  out  1  high with k_valid when round_idx = ROUNDS-1.
- busy  out  1  FSM in RUN.
- done  out  1  one-cycle pulse after the final constant is accepted.
- rd_en  in  1  random-access read enable.
- rd_addr  in  AW  random-access address.
- rd_data  out  WORD_W  random-access result.

Behaviour:
- Reset (rst_l low, asynchronous): state=IDLE. k_out, k_valid, round_idx, k_last, busy, done and rd_data all = 0.
- Constant table: a case-based ROM holding the FIPS 180-4 K values.
  - MODE=0: the 64 SHA-256 words.
  - MODE=1: the 80 SHA-512 words.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states are IDLE and RUN.
- Handshake: a constant is accepted on any rising edge where k_valid=1 and stall=0.
- IDLE → RUN: on an edge with start=1, the state goes to RUN and the outputs load k_out=K[0], round_idx=0, k_valid=1, busy=1.
  - Latency from start sampled to first valid is one edge.
- RUN, accept with round_idx < ROUNDS-1: round_idx increments, k_out=K[round_idx+1], and k_last is recomputed.
- RUN, stall=1: k_out, round_idx, k_valid and k_last hold; the state holds.
- RUN, accept with round_idx = ROUNDS-1 (final accept):
  - done=1 for exactly one cycle after this edge.
  - If start=0 on the same edge: state goes to IDLE; k_valid, k_last and busy go to 0; k_out and round_idx clear to 0.
  - If start=1 on the same edge (back-to-back restart): the stream restarts at K[0], round_idx=0, k_valid stays 1, busy stays 1. done still pulses.
- start while in RUN, other than on the final accept: ignored.
- abort: has priority over start and over accept. On the edge where it is sampled high:
  - the state goes to IDLE;
  - k_valid, k_last and busy go to 0; k_out and round_idx clear to 0;
  - done does not pulse.
  - abort in IDLE has no effect.
- Random-access port: independent of the FSM and usable in any state.
  - rd_en=1: rd_data = K[rd_addr] on the next edge.
  - rd_addr ≥ ROUNDS returns 0.
  - rd_en=0: rd_data holds its last value.
- Asynchronous reset mid-stream clears all outputs immediately. After release, a new start is required.

Test Plan:
- MODE=0, reset released, start pulsed one cycle, stall=0 throughout:
  - first edge gives k_valid=1, round_idx=0, k_out=428a2f98;
  - next gives k_out=71374491;
  - round 63 gives k_out=c67178f2 with k_last=1;
  - done pulses one cycle, then k_valid=0 and busy=0;
  - 64 consecutive valid cycles in total.
- MODE=1, same stimulus:
  - k_out=428a2f98d728ae22 at round 0;
  - 6c44198c4a475817 at round 79 with k_last=1;
  - 80 accepts, then done.
- MODE=0, stall held high for 3 cycles at round 10:
  - k_out=K[10] and round_idx=10 are stable for all 3 cycles;
  - round 11 follows on the first unstalled edge;
  - no round is skipped or duplicated.
- MODE=0, start held high through the final accept:
  - round 63 is followed directly by round 0 (428a2f98) with no k_valid gap;
  - done pulses once.
- MODE=0, abort at round 20, then start 2 cycles later:
  - k_valid=0 and busy=0 the cycle after abort, with no done pulse;
  - the new stream begins at round 0.
- Random-access port during a running stream:
  - rd_addr=63, rd_en=1 gives rd_data=c67178f2 one edge later;
  - rd_addr=100 gives 0;
  - rd_en low holds rd_data;
  - the stream outputs are unaffected throughout.
